// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller:
// FSM state encoding, ALU control codes and timeout counter sizing.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } div_state_e;

  localparam logic [5:0] DIV_CONTROL  = 6'b011010;
  localparam logic [5:0] DIVU_CONTROL = 6'b011011;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // The counter only has to reach TIMEOUT_CYCLES-1 before the request is abandoned.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Pipeline, write-back and divider signals of the divide issue controller.
// master = the controller itself, slave = pipeline plus divider side.
interface div_issue_ctrl_if;

  logic        valid_i;
  logic [5:0]  op_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        flush_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] hi_wdata_i;
  logic [31:0] lo_wdata_i;
  logic [5:0]  div_op_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        timeout_o;

  modport master (
    input  valid_i, op_i, rs_data_i, rt_data_i, flush_i,
    input  hi_we_i, lo_we_i, hi_wdata_i, lo_wdata_i,
    input  div_result_i, div_ready_i,
    output div_op_o, div_opdata1_o, div_opdata2_o, div_start_o, div_annul_o,
    output stall_o, hi_o, lo_o, timeout_o
  );

  modport slave (
    output valid_i, op_i, rs_data_i, rt_data_i, flush_i,
    output hi_we_i, lo_we_i, hi_wdata_i, lo_wdata_i,
    output div_result_i, div_ready_i,
    input  div_op_o, div_opdata1_o, div_opdata2_o, div_start_o, div_annul_o,
    input  stall_o, hi_o, lo_o, timeout_o
  );

endinterface

// File: rtl/div_issue_ctrl_hilo_reg.sv
// Architectural HI/LO pair. A divide result writes both registers and
// outranks the per-register MTHI/MTLO write port.
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_we,
  input  logic [31:0] res_hi,
  input  logic [31:0] res_lo,
  input  logic        hi_we,
  input  logic [31:0] hi_wdata,
  input  logic        lo_we,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // HI register: divide result first, then MTHI.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= 32'd0;
    end else if (res_we) begin
      hi_r <= res_hi;
    end else if (hi_we) begin
      hi_r <= hi_wdata;
    end else begin
      hi_r <= hi_r;
    end
  end

  // LO register: divide result first, then MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_r <= 32'd0;
    end else if (res_we) begin
      lo_r <= res_lo;
    end else if (lo_we) begin
      lo_r <= lo_wdata;
    end else begin
      lo_r <= lo_r;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/div_issue_ctrl.sv
// Execute-stage initiator for the iterative divider: issues DIV/DIVU, holds the
// pipeline until the result returns, and abandons requests on flush or timeout.
import div_issue_ctrl_pkg::*;

module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic           clk,
  input logic           rst,
  div_issue_ctrl_if.master bus
);

  localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  div_state_e        state_r;
  div_state_e        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              is_div_op_s;
  logic              req_s;
  logic              issue_s;
  logic              done_s;
  logic              abort_s;
  logic              timeout_s;
  logic              stall_s;

  logic [5:0]        op_r;
  logic [31:0]       opdata1_r;
  logic [31:0]       opdata2_r;
  logic              start_r;
  logic              annul_r;
  logic              timeout_r;

  // Decode a divide request that is not being flushed.
  always_comb begin
    is_div_op_s = (bus.op_i == DIV_CONTROL) || (bus.op_i == DIVU_CONTROL);
    req_s       = bus.valid_i && is_div_op_s && !bus.flush_i;
  end

  // Next state, handshake events and pipeline stall.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    timeout_s   = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          issue_s     = 1'b1;
          stall_s     = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // Flush outranks a coincident ready: the result belongs to a killed instruction.
        if (bus.flush_i) begin
          abort_s     = 1'b1;
          state_nxt_s = DRAIN;
        end else if (bus.div_ready_i) begin
          done_s      = 1'b1;
          state_nxt_s = DRAIN;
        end else if (cnt_r == CNT_LAST) begin
          abort_s     = 1'b1;
          timeout_s   = 1'b1;
          state_nxt_s = DRAIN;
        end else begin
          stall_s     = 1'b1;
          state_nxt_s = BUSY;
        end
      end
      DRAIN: begin
        // A younger divide waits here while the divider returns to its free state.
        stall_s     = req_s;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and BUSY cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (issue_s) begin
        cnt_r <= '0;
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Divider request: operands latched at issue and held stable until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= 6'd0;
      opdata1_r <= 32'd0;
      opdata2_r <= 32'd0;
      start_r   <= 1'b0;
    end else if (issue_s) begin
      op_r      <= bus.op_i;
      opdata1_r <= bus.rs_data_i;
      opdata2_r <= bus.rt_data_i;
      start_r   <= 1'b1;
    end else if (done_s || abort_s) begin
      start_r   <= 1'b0;
    end else begin
      start_r   <= start_r;
    end
  end

  // One-cycle annul and timeout pulses following an abandoned request.
  always_ff @(posedge clk) begin
    if (rst) begin
      annul_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      annul_r   <= abort_s;
      timeout_r <= timeout_s;
    end
  end

  hilo_reg u_hilo (
    .clk      (clk),
    .rst      (rst),
    .res_we   (done_s),
    .res_hi   (bus.div_result_i[63:32]),
    .res_lo   (bus.div_result_i[31:0]),
    .hi_we    (bus.hi_we_i),
    .hi_wdata (bus.hi_wdata_i),
    .lo_we    (bus.lo_we_i),
    .lo_wdata (bus.lo_wdata_i),
    .hi       (bus.hi_o),
    .lo       (bus.lo_o)
  );

  assign bus.div_op_o      = op_r;
  assign bus.div_opdata1_o = opdata1_r;
  assign bus.div_opdata2_o = opdata2_r;
  assign bus.div_start_o   = start_r;
  assign bus.div_annul_o   = annul_r;
  assign bus.timeout_o     = timeout_r;
  assign bus.stall_o       = stall_s && !rst;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a behavioural divider on the main instance, a
// never-ready divider on a short-timeout instance, vector table plus corner sequences.
import div_issue_ctrl_pkg::*;

module tb_div_issue_ctrl;

  localparam int MDL_LAT = 32;
  localparam int NV      = 7;

  logic clk;
  logic rst;

  div_issue_ctrl_if bus_m ();
  div_issue_ctrl_if bus_t ();

  div_issue_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  div_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vec [NV];
  exp_t sb_q [$];
  int   total;
  int   bad;

  // Behavioural iterative divider: fixed latency, one-cycle ready, cleared by annul.
  logic        mdl_busy;
  logic        mdl_rdy;
  int          mdl_cnt;
  logic [63:0] mdl_res;
  logic        force_rdy;
  logic [63:0] force_res;

  function automatic logic [63:0] div_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (op == DIV_CONTROL) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_rdy  <= 1'b0;
      mdl_cnt  <= 0;
      mdl_res  <= 64'd0;
    end else if (bus_m.div_annul_o || mdl_rdy) begin
      mdl_busy <= 1'b0;
      mdl_rdy  <= 1'b0;
    end else if (!mdl_busy && bus_m.div_start_o) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 0;
    end else if (mdl_busy) begin
      if (mdl_cnt == MDL_LAT - 1) begin
        mdl_rdy <= 1'b1;
        mdl_res <= div_ref(bus_m.div_op_o, bus_m.div_opdata1_o, bus_m.div_opdata2_o);
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  assign bus_m.div_ready_i  = mdl_rdy || force_rdy;
  assign bus_m.div_result_i = force_rdy ? force_res : mdl_res;
  assign bus_t.div_ready_i  = 1'b0;
  assign bus_t.div_result_i = 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_hi"}, bus_m.hi_o, e.hi);
      chk({name, "_lo"}, bus_m.lo_o, e.lo);
    end
  endtask

  // Leaves the DUT in the BUSY cycle where ready is seen (stall released).
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus_m.stall_o === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_ready_seen"}, (n < 200), 64'd1);
    chk({name, "_stall_len"}, (n >= MDL_LAT), 64'd1);
  endtask

  task automatic issue_and_wait(input string name, input logic [5:0] op,
                                input logic [31:0] rs, input logic [31:0] rt);
    bus_m.valid_i   = 1'b1;
    bus_m.op_i      = op;
    bus_m.rs_data_i = rs;
    bus_m.rt_data_i = rt;
    #1;
    chk({name, "_issue_stall"}, bus_m.stall_o, 64'd1);
    tick();
    chk({name, "_start"}, bus_m.div_start_o, 64'd1);
    chk({name, "_opdata1"}, bus_m.div_opdata1_o, rs);
    chk({name, "_opdata2"}, bus_m.div_opdata2_o, rt);
    wait_ready(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    vec[0] = '{DIVU_CONTROL, 32'd100,        32'd7,          32'd2,          32'd14};
    vec[1] = '{DIV_CONTROL,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
    vec[2] = '{DIVU_CONTROL, 32'd12345,      32'd0,          32'd0,          32'd0};
    vec[3] = '{DIV_CONTROL,  32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2};
    vec[4] = '{DIVU_CONTROL, 32'hFFFF_FFFF,  32'd16,         32'd15,         32'h0FFF_FFFF};
    vec[5] = '{DIV_CONTROL,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd14};
    vec[6] = '{DIVU_CONTROL, 32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC};

    rst       = 1'b1;
    force_rdy = 1'b0;
    force_res = 64'd0;
    bus_m.valid_i = 1'b1; bus_m.op_i = DIV_CONTROL; bus_m.rs_data_i = 32'd5; bus_m.rt_data_i = 32'd1;
    bus_m.flush_i = 1'b0; bus_m.hi_we_i = 1'b0; bus_m.lo_we_i = 1'b0;
    bus_m.hi_wdata_i = 32'd0; bus_m.lo_wdata_i = 32'd0;
    bus_t.valid_i = 1'b0; bus_t.op_i = 6'd0; bus_t.rs_data_i = 32'd0; bus_t.rt_data_i = 32'd0;
    bus_t.flush_i = 1'b0; bus_t.hi_we_i = 1'b0; bus_t.lo_we_i = 1'b0;
    bus_t.hi_wdata_i = 32'd0; bus_t.lo_wdata_i = 32'd0;

    // Reset state, with a divide request held during reset.
    tick(); tick(); tick();
    chk("rst_stall", bus_m.stall_o, 64'd0);
    chk("rst_start", bus_m.div_start_o, 64'd0);
    chk("rst_annul", bus_m.div_annul_o, 64'd0);
    chk("rst_op", bus_m.div_op_o, 64'd0);
    chk("rst_hilo", {bus_m.hi_o, bus_m.lo_o}, 64'd0);
    chk("rst_timeout", bus_m.timeout_o, 64'd0);
    bus_m.valid_i = 1'b0;
    rst = 1'b0;
    tick();

    // Vector table through the behavioural divider.
    for (int i = 0; i < NV; i++) begin
      sb_q.push_back('{vec[i].hi, vec[i].lo});
      issue_and_wait($sformatf("vec%0d", i), vec[i].op, vec[i].rs, vec[i].rt);
      bus_m.valid_i = 1'b0;
      tick();
      pop_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_start_low", i), bus_m.div_start_o, 64'd0);
      chk($sformatf("vec%0d_no_timeout", i), bus_m.timeout_o, 64'd0);
      chk($sformatf("vec%0d_drain_nostall", i), bus_m.stall_o, 64'd0);
      tick();
    end

    // MTHI/MTLO update only their own register.
    bus_m.lo_we_i = 1'b1; bus_m.lo_wdata_i = 32'h0000_1234;
    tick();
    bus_m.lo_we_i = 1'b0;
    chk("mtlo_lo", bus_m.lo_o, 64'h1234);
    chk("mtlo_hi", bus_m.hi_o, 64'd1);
    bus_m.hi_we_i = 1'b1; bus_m.hi_wdata_i = 32'h0000_ABCD;
    tick();
    bus_m.hi_we_i = 1'b0;
    chk("mthi_hilo", {bus_m.hi_o, bus_m.lo_o}, 64'h0000_ABCD_0000_1234);

    // Ready while IDLE is ignored.
    force_res = 64'h1111_2222_3333_4444;
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    chk("idle_ready_hilo", {bus_m.hi_o, bus_m.lo_o}, 64'h0000_ABCD_0000_1234);
    chk("idle_ready_start", bus_m.div_start_o, 64'd0);

    // Non-divide op is ignored.
    bus_m.valid_i = 1'b1; bus_m.op_i = 6'b100000;
    #1;
    chk("nondiv_stall", bus_m.stall_o, 64'd0);
    tick();
    chk("nondiv_start", bus_m.div_start_o, 64'd0);
    bus_m.valid_i = 1'b0;

    // Flush 10 cycles into BUSY.
    bus_m.valid_i = 1'b1; bus_m.op_i = DIVU_CONTROL; bus_m.rs_data_i = 32'd50; bus_m.rt_data_i = 32'd5;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("flush_busy_stall", bus_m.stall_o, 64'd1);
      tick();
    end
    bus_m.flush_i = 1'b1;
    #1;
    chk("flush_stall", bus_m.stall_o, 64'd0);
    tick();
    bus_m.flush_i = 1'b0;
    bus_m.valid_i = 1'b0;
    chk("flush_annul", bus_m.div_annul_o, 64'd1);
    chk("flush_start", bus_m.div_start_o, 64'd0);
    chk("flush_timeout", bus_m.timeout_o, 64'd0);
    tick();
    chk("flush_annul_drop", bus_m.div_annul_o, 64'd0);
    for (int i = 0; i < 40; i++) tick();
    chk("flush_hilo", {bus_m.hi_o, bus_m.lo_o}, 64'h0000_ABCD_0000_1234);

    // Back-to-back divides with MTHI coincident with the first completion.
    sb_q.push_back('{32'd0, 32'd3});
    issue_and_wait("b2b1", DIVU_CONTROL, 32'd9, 32'd3);
    bus_m.hi_we_i = 1'b1; bus_m.hi_wdata_i = 32'h0000_0055;
    bus_m.rs_data_i = 32'd10; bus_m.rt_data_i = 32'd4;
    tick();
    bus_m.hi_we_i = 1'b0;
    pop_check("b2b1");
    chk("b2b_drain_stall", bus_m.stall_o, 64'd1);
    chk("b2b_drain_start", bus_m.div_start_o, 64'd0);
    sb_q.push_back('{32'd2, 32'd2});
    tick();
    chk("b2b_idle_stall", bus_m.stall_o, 64'd1);
    chk("b2b_idle_start", bus_m.div_start_o, 64'd0);
    tick();
    chk("b2b2_start", bus_m.div_start_o, 64'd1);
    chk("b2b2_opdata", {bus_m.div_opdata1_o, bus_m.div_opdata2_o}, {32'd10, 32'd4});
    wait_ready("b2b2");
    bus_m.valid_i = 1'b0;
    tick();
    pop_check("b2b2");
    tick();

    // Never-ready divider on the TIMEOUT_CYCLES=8 instance.
    begin
      int n;
      bus_t.valid_i = 1'b1; bus_t.op_i = DIVU_CONTROL; bus_t.rs_data_i = 32'd7; bus_t.rt_data_i = 32'd1;
      #1;
      chk("to_issue_stall", bus_t.stall_o, 64'd1);
      tick();
      n = 0;
      while (bus_t.timeout_o !== 1'b1 && n < 20) begin
        if (n == 3) chk("to_busy_stall", bus_t.stall_o, 64'd1);
        if (n == 7) begin
          chk("to_stall_release", bus_t.stall_o, 64'd0);
          bus_t.valid_i = 1'b0;
        end
        tick();
        n++;
      end
      bus_t.valid_i = 1'b0;
      chk("to_cycles", n, 64'd8);
      chk("to_annul", bus_t.div_annul_o, 64'd1);
      chk("to_start", bus_t.div_start_o, 64'd0);
      chk("to_hilo", {bus_t.hi_o, bus_t.lo_o}, 64'd0);
      tick();
      chk("to_pulse_len", bus_t.timeout_o, 64'd0);
      chk("to_annul_len", bus_t.div_annul_o, 64'd0);
    end

    // Reset in the middle of BUSY.
    bus_m.valid_i = 1'b1; bus_m.op_i = DIV_CONTROL; bus_m.rs_data_i = 32'd77; bus_m.rt_data_i = 32'd7;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", bus_m.stall_o, 64'd0);
    tick();
    chk("mid_rst_start_annul", {bus_m.div_start_o, bus_m.div_annul_o, bus_m.timeout_o}, 64'd0);
    chk("mid_rst_op", bus_m.div_op_o, 64'd0);
    chk("mid_rst_opdata", {bus_m.div_opdata1_o, bus_m.div_opdata2_o}, 64'd0);
    chk("mid_rst_hilo", {bus_m.hi_o, bus_m.lo_o}, 64'd0);
    rst = 1'b0;
    bus_m.valid_i = 1'b0;
    tick();
    tick();
    chk("post_rst_start", bus_m.div_start_o, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
